// File: rtl/mfcc_frame_scheduler.sv
// MFCC frame scheduler: launches window moves, tracks frames through the
// back-end by done pulses, with credit limit, stop/auto control and watchdog.
module mfcc_frame_scheduler #(
   parameter int MAX_INFLIGHT    = 2,
   parameter int TIMEOUT_CYCLES  = 100000,
   parameter int FRAME_CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start_i,
   input  logic                       auto_restart_i,
   input  logic                       stop_i,
   input  logic                       window_idle_i,
   input  logic                       hamming_done_i,
   input  logic                       fft_done_i,
   input  logic                       mel_done_i,
   input  logic                       dct_done_i,
   output logic                       start_move_o,
   output logic                       busy_o,
   output logic                       frame_done_o,
   output logic [FRAME_CNT_WIDTH-1:0] frame_count_o,
   output logic [2:0]                 inflight_o,
   output logic                       timeout_o
);

   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [2:0]     MAXI   = 3'(MAX_INFLIGHT);
   localparam logic [WDW-1:0] WD_TOP = WDW'(TIMEOUT_CYCLES - 2);

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_LAUNCH, S_WAIT_WIN, S_DRAIN, S_ERROR
   } state_t;

   state_t r_state, w_next;

   logic                       r_stop;
   logic [2:0]                 r_inflight;
   logic [WDW-1:0]             r_wd;
   logic [FRAME_CNT_WIDTH-1:0] r_fcnt;
   logic                       r_start_move;
   logic                       r_frame_done;
   logic                       r_timeout;

   logic w_any_done, w_dct_cnt, w_launch;
   logic w_wd_run, w_wd_clr, w_wd_hit;
   logic w_stop, w_clear;

   assign w_any_done = hamming_done_i | fft_done_i
                     | mel_done_i | dct_done_i;
   assign w_dct_cnt  = dct_done_i && (r_inflight != 3'd0);
   assign w_launch   = (r_state == S_LAUNCH);
   assign w_wd_run   = (r_state == S_WAIT_WIN || r_inflight != 3'd0)
                     && (r_state != S_ERROR);
   assign w_wd_clr   = w_launch || w_any_done;
   assign w_wd_hit   = w_wd_run && !w_wd_clr && (r_wd == WD_TOP);
   assign w_stop     = r_stop | stop_i;
   assign w_clear    = (r_state == S_ERROR) && start_i;

   // Next-state decision; watchdog expiry overrides any other move
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:
            if (start_i && !stop_i) w_next = S_ARM;
         S_ARM:
            if (w_stop)
               w_next = S_DRAIN;
            else if (window_idle_i && r_inflight < MAXI)
               w_next = S_LAUNCH;
         S_LAUNCH:
            w_next = S_WAIT_WIN;
         S_WAIT_WIN:
            if (hamming_done_i)
               w_next = (w_stop || !auto_restart_i) ? S_DRAIN : S_ARM;
         S_DRAIN:
            if (r_inflight == 3'd0) w_next = S_IDLE;
         S_ERROR:
            if (start_i) w_next = S_IDLE;
         default:
            w_next = S_IDLE;
      endcase
      if (w_wd_hit) w_next = S_ERROR;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Stop request held until the scheduler is back in IDLE
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_stop <= 1'b0;
      else if (w_next == S_IDLE)
         r_stop <= 1'b0;
      else if (stop_i && r_state != S_IDLE && r_state != S_ERROR)
         r_stop <= 1'b1;
   end

   // Frames in flight: +1 per launch, -1 per dct done, never below 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_inflight <= 3'd0;
      else if (w_clear)
         r_inflight <= 3'd0;
      else if (w_launch && !w_dct_cnt)
         r_inflight <= r_inflight + 3'd1;
      else if (!w_launch && w_dct_cnt)
         r_inflight <= r_inflight - 3'd1;
   end

   // Watchdog counts only while work is pending
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_wd <= '0;
      else if (w_clear || w_wd_clr || !w_wd_run)
         r_wd <= '0;
      else
         r_wd <= r_wd + WDW'(1);
   end

   // Completed-frame counter, wraps naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_fcnt <= '0;
      else if (w_clear)
         r_fcnt <= '0;
      else if (w_dct_cnt)
         r_fcnt <= r_fcnt + FRAME_CNT_WIDTH'(1);
   end

   // Registered pulses and sticky timeout flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_start_move <= 1'b0;
         r_frame_done <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_start_move <= (w_next == S_LAUNCH);
         r_frame_done <= dct_done_i;
         if (w_clear)       r_timeout <= 1'b0;
         else if (w_wd_hit) r_timeout <= 1'b1;
      end
   end

   assign start_move_o  = r_start_move;
   assign busy_o        = (r_state != S_IDLE);
   assign frame_done_o  = r_frame_done;
   assign frame_count_o = r_fcnt;
   assign inflight_o    = r_inflight;
   assign timeout_o     = r_timeout;

endmodule

// File: tb/tb_mfcc_frame_scheduler.sv
// Scoreboard bench for mfcc_frame_scheduler: directed scenarios push
// expected output events; a negedge monitor pops and compares them.
module tb_mfcc_frame_scheduler;

   localparam int FCW = 16;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start_i = 1'b0;
   logic           auto_restart_i = 1'b0;
   logic           stop_i = 1'b0;
   logic           window_idle_i = 1'b1;
   logic           hamming_done_i = 1'b0;
   logic           fft_done_i = 1'b0;
   logic           mel_done_i = 1'b0;
   logic           dct_done_i = 1'b0;
   logic           start_move_o;
   logic           busy_o;
   logic           frame_done_o;
   logic [FCW-1:0] frame_count_o;
   logic [2:0]     inflight_o;
   logic           timeout_o;

   mfcc_frame_scheduler #(
      .MAX_INFLIGHT(2), .TIMEOUT_CYCLES(50), .FRAME_CNT_WIDTH(FCW)
   ) dut (
      .clk(clk), .rst(rst), .start_i(start_i),
      .auto_restart_i(auto_restart_i), .stop_i(stop_i),
      .window_idle_i(window_idle_i), .hamming_done_i(hamming_done_i),
      .fft_done_i(fft_done_i), .mel_done_i(mel_done_i),
      .dct_done_i(dct_done_i), .start_move_o(start_move_o),
      .busy_o(busy_o), .frame_done_o(frame_done_o),
      .frame_count_o(frame_count_o), .inflight_o(inflight_o),
      .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int kind;
      int cyc;
      int fc;
      int infl;
   } ev_t;

   ev_t q[$];
   int  n_chk  = 0;
   int  n_pass = 0;

   localparam logic [5:0] START = 6'h01;
   localparam logic [5:0] STOP  = 6'h02;
   localparam logic [5:0] HAM   = 6'h04;
   localparam logic [5:0] FFT   = 6'h08;
   localparam logic [5:0] MEL   = 6'h10;
   localparam logic [5:0] DCT   = 6'h20;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                    name, act, exp, cyc);
   endtask

   task automatic expect_ev(input int kind, input int c,
                            input int fc, input int infl);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      e.fc   = fc;
      e.infl = infl;
      q.push_back(e);
   endtask

   task automatic pop_check(input int kind);
      ev_t e;
      string nm;
      nm = (kind == 0) ? "start_move" : "frame_done";
      if (q.size() == 0) begin
         n_chk++;
         $display("FAIL unexpected_%s: got pulse expected none (cycle %0d)",
                  nm, cyc);
      end else begin
         e = q.pop_front();
         check({nm, "_kind"}, kind, e.kind);
         check({nm, "_cycle"}, cyc, e.cyc);
         check({nm, "_frame_count"}, int'(frame_count_o), e.fc);
         check({nm, "_inflight"}, int'(inflight_o), e.infl);
      end
   endtask

   // Monitor: every output pulse must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (start_move_o) pop_check(0);
         if (frame_done_o) pop_check(1);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [5:0] m);
      start_i        = m[0];
      stop_i         = m[1];
      hamming_done_i = m[2];
      fft_done_i     = m[3];
      mel_done_i     = m[4];
      dct_done_i     = m[5];
      step();
      start_i        = 1'b0;
      stop_i         = 1'b0;
      hamming_done_i = 1'b0;
      fft_done_i     = 1'b0;
      mel_done_i     = 1'b0;
      dct_done_i     = 1'b0;
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) step();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int c;
      // reset state
      step();
      step();
      check("rst_busy", int'(busy_o), 0);
      check("rst_start_move", int'(start_move_o), 0);
      check("rst_frame_done", int'(frame_done_o), 0);
      check("rst_frame_count", int'(frame_count_o), 0);
      check("rst_inflight", int'(inflight_o), 0);
      check("rst_timeout", int'(timeout_o), 0);
      rst = 1'b0;
      step();

      // single-shot frame
      c = cyc;
      expect_ev(0, c + 2, 0, 0);
      pulse(START);
      wait_to(c + 10);
      check("t1_busy", int'(busy_o), 1);
      check("t1_inflight", int'(inflight_o), 1);
      wait_to(c + 20);  pulse(HAM);
      wait_to(c + 60);  pulse(FFT);
      wait_to(c + 100); pulse(MEL);
      wait_to(c + 140); pulse(FFT);
      wait_to(c + 180); pulse(MEL);
      wait_to(c + 200);
      expect_ev(1, c + 201, 1, 0);
      pulse(DCT);
      wait_to(c + 205);
      check("t1_idle_busy", int'(busy_o), 0);
      check("t1_frame_count", int'(frame_count_o), 1);
      check("t1_inflight_end", int'(inflight_o), 0);

      // auto-restart up to credit limit, then stop and drain
      auto_restart_i = 1'b1;
      c = cyc;
      expect_ev(0, c + 2, 1, 0);
      pulse(START);
      wait_to(c + 5);
      pulse(HAM);
      expect_ev(0, c + 7, 1, 1);
      wait_to(c + 10);
      pulse(HAM);
      wait_to(c + 25);
      check("t2_inflight_cap", int'(inflight_o), 2);
      check("t2_busy", int'(busy_o), 1);
      window_idle_i = 1'b0;
      wait_to(c + 30);
      expect_ev(1, c + 31, 2, 1);
      pulse(DCT);
      wait_to(c + 35);
      expect_ev(0, c + 36, 2, 1);
      window_idle_i = 1'b1;
      wait_to(c + 40);
      check("t3_inflight_2", int'(inflight_o), 2);
      pulse(STOP);
      wait_to(c + 45);
      pulse(HAM);
      wait_to(c + 50);
      expect_ev(1, c + 51, 3, 1);
      pulse(DCT);
      wait_to(c + 58);
      check("t3_drain_busy", int'(busy_o), 1);
      wait_to(c + 60);
      expect_ev(1, c + 61, 4, 0);
      pulse(DCT);
      wait_to(c + 64);
      check("t3_idle_busy", int'(busy_o), 0);
      check("t3_frame_count", int'(frame_count_o), 4);
      auto_restart_i = 1'b0;

      // watchdog expiry and error clear
      c = cyc;
      expect_ev(0, c + 2, 4, 0);
      pulse(START);
      wait_to(c + 51);
      check("t4_timeout_early", int'(timeout_o), 0);
      check("t4_busy", int'(busy_o), 1);
      step();
      check("t4_timeout_set", int'(timeout_o), 1);
      check("t4_inflight_err", int'(inflight_o), 1);
      wait_to(c + 60);
      pulse(START);
      check("t4_timeout_clr", int'(timeout_o), 0);
      check("t4_count_clr", int'(frame_count_o), 0);
      check("t4_inflight_clr", int'(inflight_o), 0);
      check("t4_busy_clr", int'(busy_o), 0);

      // launch coincident with dct done; dct done at zero inflight
      auto_restart_i = 1'b1;
      c = cyc;
      expect_ev(0, c + 2, 0, 0);
      pulse(START);
      wait_to(c + 5);
      pulse(HAM);
      wait_to(c + 7);
      expect_ev(0, c + 7, 0, 1);
      expect_ev(1, c + 8, 1, 1);
      pulse(DCT);
      check("t5_inflight_same", int'(inflight_o), 1);
      wait_to(c + 10);
      pulse(STOP);
      wait_to(c + 12);
      pulse(HAM);
      wait_to(c + 15);
      expect_ev(1, c + 16, 2, 0);
      pulse(DCT);
      wait_to(c + 18);
      check("t5_idle_busy", int'(busy_o), 0);
      wait_to(c + 20);
      expect_ev(1, c + 21, 2, 0);
      pulse(DCT);
      step();
      check("t5_count_hold", int'(frame_count_o), 2);
      check("t5_no_underflow", int'(inflight_o), 0);
      auto_restart_i = 1'b0;
      wait_to(c + 25);
      pulse(START | STOP);
      check("t5_start_stop_idle", int'(busy_o), 0);
      step();
      check("t5_start_stop_idle2", int'(busy_o), 0);

      // async reset during WAIT_WIN
      c = cyc;
      expect_ev(0, c + 2, 2, 0);
      pulse(START);
      wait_to(c + 6);
      check("t6_busy_pre", int'(busy_o), 1);
      check("t6_inflight_pre", int'(inflight_o), 1);
      rst = 1'b1;
      #1;
      check("t6_rst_busy", int'(busy_o), 0);
      check("t6_rst_inflight", int'(inflight_o), 0);
      check("t6_rst_count", int'(frame_count_o), 0);
      check("t6_rst_start_move", int'(start_move_o), 0);
      step();
      step();
      rst = 1'b0;
      c = cyc;
      expect_ev(1, c + 1, 0, 0);
      pulse(HAM | DCT);
      check("t6_late_done_count", int'(frame_count_o), 0);
      check("t6_late_done_busy", int'(busy_o), 0);
      c = cyc;
      expect_ev(0, c + 2, 0, 0);
      pulse(START);
      wait_to(c + 5);
      pulse(HAM);
      wait_to(c + 8);
      expect_ev(1, c + 9, 1, 0);
      pulse(DCT);
      wait_to(c + 12);
      check("t6_final_busy", int'(busy_o), 0);
      check("t6_final_count", int'(frame_count_o), 1);

      wait_to(cyc + 5);
      check("scoreboard_empty", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
